// File: rtl/canvas_cursor_if.sv
// Button/level inputs and cursor/pixel-write outputs of the canvas cursor stage.
interface canvas_cursor_if #(
  parameter int COORD_W = 4
);
  logic [3:0]         buttons;   // {up, down, right, left}
  logic [2:0]         color;
  logic               brush;
  logic [COORD_W-1:0] cursor_x;
  logic [COORD_W-1:0] cursor_y;
  logic               pix_we;
  logic [2:0]         pix_color;
  logic [3:0]         btn_db;

  modport master (
    output buttons, color, brush,
    input  cursor_x, cursor_y, pix_we, pix_color, btn_db
  );

  modport slave (
    input  buttons, color, brush,
    output cursor_x, cursor_y, pix_we, pix_color, btn_db
  );
endinterface

// File: rtl/canvas_cursor.sv
// Button conditioning (sync, debounce, press edge, auto-repeat) driving a clamped
// canvas cursor that emits a one-cycle pixel write on every step.
module canvas_cursor #(
  parameter int GRID_W       = 16,
  parameter int GRID_H       = 16,
  parameter int COORD_W      = 4,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int REPEAT_DELAY = 5000000,
  parameter int REPEAT_RATE  = 1000000
) (
  input logic             clk,
  input logic             rst_n,
  canvas_cursor_if.slave  io_bus
);
  localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TMR_W-1:0]   DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0]   RATE_LAST  = TMR_W'(REPEAT_RATE - 1);
  localparam logic [COORD_W-1:0] X_MAX      = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX      = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] X_RST      = COORD_W'(GRID_W / 2);
  localparam logic [COORD_W-1:0] Y_RST      = COORD_W'(GRID_H / 2);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  logic [3:0]         r_sync1, r_sync2, r_db, r_db_prev;
  logic [DB_W-1:0]    r_db_cnt [4];
  state_t             r_state, w_state_nxt;
  logic [TMR_W-1:0]   r_tmr, w_tmr_nxt;
  logic               r_step, w_step;
  logic [3:0]         r_step_dir;
  logic [COORD_W-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic               r_pix_we;
  logic [2:0]         r_pix_color;
  logic [3:0]         w_press;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_db      <= '0;
      r_db_prev <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1   <= io_bus.buttons;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= ~r_db[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign w_press = r_db & ~r_db_prev;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr + TMR_W'(1);
    w_step      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_tmr_nxt = '0;
        if (|w_press) begin
          w_step      = 1'b1;
          w_state_nxt = DELAY;
        end
      end
      DELAY: begin
        if (r_db == 4'b0000) begin
          w_state_nxt = IDLE;
          w_tmr_nxt   = '0;
        end else if (|w_press) begin
          w_step    = 1'b1;
          w_tmr_nxt = '0;
        end else if (r_tmr == DELAY_LAST) begin
          w_step      = 1'b1;
          w_tmr_nxt   = '0;
          w_state_nxt = REPEAT;
        end
      end
      REPEAT: begin
        if (r_db == 4'b0000) begin
          w_state_nxt = IDLE;
          w_tmr_nxt   = '0;
        end else if (|w_press) begin
          w_step      = 1'b1;
          w_tmr_nxt   = '0;
          w_state_nxt = DELAY;
        end else if (r_tmr == RATE_LAST) begin
          w_step    = 1'b1;
          w_tmr_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_tmr      <= '0;
      r_step     <= 1'b0;
      r_step_dir <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_step  <= w_step;
      if (w_step) r_step_dir <= r_db;
    end
  end

  // Opposite buttons cancel; each axis saturates at the canvas edge.
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    if (r_step_dir[1] && !r_step_dir[0] && r_x < X_MAX)       w_x_nxt = r_x + COORD_W'(1);
    else if (r_step_dir[0] && !r_step_dir[1] && r_x > '0)     w_x_nxt = r_x - COORD_W'(1);
    if (r_step_dir[2] && !r_step_dir[3] && r_y < Y_MAX)       w_y_nxt = r_y + COORD_W'(1);
    else if (r_step_dir[3] && !r_step_dir[2] && r_y > '0)     w_y_nxt = r_y - COORD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x         <= X_RST;
      r_y         <= Y_RST;
      r_pix_we    <= 1'b0;
      r_pix_color <= 3'b000;
    end else begin
      r_pix_we <= r_step;
      if (r_step) begin
        r_x         <= w_x_nxt;
        r_y         <= w_y_nxt;
        r_pix_color <= io_bus.brush ? io_bus.color : 3'b000;
      end
    end
  end

  assign io_bus.cursor_x  = r_x;
  assign io_bus.cursor_y  = r_y;
  assign io_bus.pix_we    = r_pix_we;
  assign io_bus.pix_color = r_pix_color;
  assign io_bus.btn_db    = r_db;
endmodule
